// File: rtl/note_writer.sv
// Sequential page writer for the 512x16 note BRAM: accepts BURST note words over a
// valid/ready stream and writes them to consecutive (wrapping) addresses, then pulses done.
module note_writer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int BURST  = 32,
  localparam int CNT_W = $clog2(BURST) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  input  logic              note_valid,
  input  logic [DATA_W-1:0] note_data,
  output logic              note_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Debug encoding on dbg_state: IDLE=0, WRITE=1, DONE=2.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              last_word;

  // Handshake: a word transfers on a rising edge where note_valid && note_ready;
  // ready is only offered in WRITE and is withdrawn combinationally by abort.
  assign note_ready = (state == WRITE) && !abort;
  assign accept     = note_valid && note_ready;
  assign last_word  = (count == CNT_W'(BURST - 1));

  assign busy      = (state == WRITE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      count      <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      bram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= start_addr;
            count <= '0;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            bram_we    <= 1'b1;
            bram_addr  <= ptr;
            bram_wdata <= note_data;
            // Pointer wraps naturally at the top of the address space.
            ptr        <= ptr + ADDR_W'(1);
            count      <= count + CNT_W'(1);
            if (last_word) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_writer.sv
// Directed-plus-random bench for note_writer, checked cycle by cycle against a
// page-level reference model (base address, words accepted, expected write queue).
module tb_note_writer;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int BURST  = 32;
  localparam int CNT_W  = $clog2(BURST) + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_WRITE = 1;
  localparam int PH_DONE  = 2;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              abort;
  logic              note_valid;
  logic [DATA_W-1:0] note_data;
  logic              note_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  note_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .note_valid (note_valid),
    .note_data  (note_data),
    .note_ready (note_ready),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: page phase, page base, words accepted, pending writes
  int                       m_phase;
  logic [ADDR_W-1:0]        m_base;
  int                       m_n;
  logic                     exp_we;
  logic [ADDR_W-1:0]        last_addr;
  logic [DATA_W-1:0]        last_data;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_base    = '0;
    m_n       = 0;
    exp_we    = 1'b0;
    last_addr = '0;
    last_data = '0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(note_ready), 0);
    check({tag, "_we"},    32'(bram_we), 0);
    check({tag, "_addr"},  32'(bram_addr), 0);
    check({tag, "_wdata"}, 32'(bram_wdata), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  // driver: one clock cycle of stimulus, model update and output checks
  task automatic drive_cycle(input logic st, input logic [ADDR_W-1:0] sa, input logic ab,
                             input logic v, input logic [DATA_W-1:0] d);
    logic exp_ready;
    logic acc;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W+DATA_W-1:0] ent;
    @(negedge clk);
    start = st; start_addr = sa; abort = ab; note_valid = v; note_data = d;
    #1;
    exp_ready = (m_phase == PH_WRITE) && !ab;
    check("note_ready", 32'(note_ready), 32'(exp_ready));
    acc    = v && exp_ready;
    exp_we = acc;
    if (acc) begin
      wa = ADDR_W'((int'(m_base) + m_n) % DEPTH);
      exp_q.push_back({wa, d});
      m_n++;
    end
    case (m_phase)
      PH_IDLE:  if (st) begin m_phase = PH_WRITE; m_base = sa; m_n = 0; end
      PH_WRITE: if (ab) m_phase = PH_IDLE;
                else if (acc && m_n == BURST) m_phase = PH_DONE;
      default:  m_phase = PH_IDLE;
    endcase
    @(posedge clk);
    #1;
    check("bram_we", 32'(bram_we), 32'(exp_we));
    if (exp_we && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      last_addr = ent[ADDR_W+DATA_W-1:DATA_W];
      last_data = ent[DATA_W-1:0];
    end
    check("bram_addr",  32'(bram_addr), 32'(last_addr));
    check("bram_wdata", 32'(bram_wdata), 32'(last_data));
    check("count",      32'(count), 32'(m_n));
    check("busy",       32'(busy), 32'(m_phase == PH_WRITE));
    check("done",       32'(done), 32'(m_phase == PH_DONE));
    check("state",      32'(dbg_state), 32'(m_phase));
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; note_valid = 1'b0; note_data = '0; start_addr = '0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode 0: sequential data 0x1000+i, valid held; mode 1: random data and valid gaps
  task automatic run_page(input logic [ADDR_W-1:0] sa, input int mode);
    int guard;
    drive_cycle(1'b1, sa, 1'b0, 1'b0, '0);
    guard = 0;
    while (m_phase != PH_IDLE && guard < 600) begin
      if (mode == 0) drive_cycle(1'b0, '0, 1'b0, 1'b1, DATA_W'(16'h1000 + m_n));
      else drive_cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
      guard++;
    end
    if (guard >= 600) check("page_timeout", 32'(m_phase), PH_IDLE);
  endtask

  task automatic run_until_n(input int n);
    int guard;
    guard = 0;
    while (m_n < n && m_phase == PH_WRITE && guard < 400) begin
      drive_cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
      guard++;
    end
    if (guard >= 400) check("run_timeout", 32'(m_n), 32'(n));
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; start_addr = '0; abort = 1'b0; note_valid = 1'b0; note_data = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // basic page at 0x040 with 0x1000..0x101F back to back
    run_page(9'h040, 0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);

    // wrap page at 500
    run_page(9'd500, 0);

    // backpressure gaps at random bases
    for (int p = 0; p < 3; p++) run_page(ADDR_W'($urandom_range(0, DEPTH - 1)), 1);

    // abort together with valid after 10 accepts
    drive_cycle(1'b1, 9'd200, 1'b0, 1'b0, '0);
    run_until_n(10);
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 16'hdead);
    check("abort_count", 32'(count), 10);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 16'hbeef);

    // asynchronous reset mid-page
    drive_cycle(1'b1, 9'd300, 1'b0, 1'b0, '0);
    run_until_n(5);
    async_reset("midreset");

    // restart, then a start pulse during WRITE that must be ignored
    drive_cycle(1'b1, 9'd100, 1'b0, 1'b0, '0);
    run_until_n(8);
    drive_cycle(1'b1, 9'd300, 1'b0, 1'b1, 16'h5a5a);
    run_until_n(BURST);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);

    // start and abort together in IDLE: start wins
    drive_cycle(1'b1, 9'd7, 1'b1, 1'b0, '0);
    run_until_n(BURST);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);

    // random soak over all inputs
    for (int c = 0; c < 600; c++) begin
      drive_cycle(1'($urandom_range(0, 3) == 0), ADDR_W'($urandom_range(0, DEPTH - 1)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), DATA_W'($urandom));
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);

    check("exp_q_empty", 32'(exp_q.size()), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_writer.md
# note_writer

Sequential writer for the 512x16 note memory. On a `start` pulse it accepts exactly 32 16-bit note words over a valid/ready stream and writes them to consecutive BRAM addresses from a given start address, one word per cycle. It then pulses `done`. It is the write side of the note BRAM: it fills a 32-note page that the note loader later reads back in order.

## Interface
Parameters:
- `ADDR_W` = 9: BRAM address width (512 locations).
- `DATA_W` = 16: note word width.
- `BURST` = 32: words per page; must be a power of two ≤ 2^ADDR_W.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a page write; sampled only in IDLE.
- `start_addr`  in  ADDR_W: first BRAM address of the page; latched with `start`.
- `abort`  in  1: cancel the page in progress.
- `note_valid`  in  1: source has a word on `note_data`.
- `note_data`  in  DATA_W: note word.
- `note_ready`  out  1: writer accepts a word this cycle.
- `bram_we`  out  1: BRAM write enable.
- `bram_addr`  out  ADDR_W: BRAM write address.
- `bram_wdata`  out  DATA_W: BRAM write data.
- `count`  out  $clog2(BURST)+1: words accepted in the current or last page (0..32).
- `busy`  out  1: state is WRITE.
- `done`  out  1: one-cycle pulse when a full page has been written.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - `note_ready`=0.
  - `start`=1 latches `start_addr` into the write pointer, clears `count`, and moves to WRITE.
- WRITE:
  - `note_ready` = !`abort` (combinational).
  - Accept = `note_valid` && `note_ready`.
  - On accept: `bram_we`/`bram_addr`/`bram_wdata` are registered with the pointer and data. The pointer increments modulo 2^ADDR_W and `count` increments.
  - When the accept makes `count` reach BURST, the next state is DONE.
  - `abort`=1 returns to IDLE. No handshake completes in that cycle. Words already written stay in BRAM. No `done`. `count` holds the number of words written.
- DONE: `done`=1 for exactly this cycle, then IDLE unconditionally.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `start` wins, since `abort` has meaning only in WRITE.
- Address wrap: the pointer wraps 511→0 silently. Example: a page at 500 writes 500..511, then 0..19.
- `note_valid` gaps in WRITE stall the page indefinitely. There is no timeout.
- `bram_addr`/`bram_wdata` hold their last values when `bram_we`=0.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State goes to IDLE.
  - `note_ready`, `bram_we`, `bram_addr`, `bram_wdata`, `count`, `busy` and `done` all go to 0.
  - The latched address is cleared.
  - Reset mid-page abandons the page. Partial BRAM contents are left as written.
- `start` at edge N puts the block in WRITE. `busy`=1 and `note_ready`=1 are visible in cycle N+1.
- An accept at edge K produces `bram_we`=1 with that word in cycle K+1. The write latency is 1 cycle.
- Throughput is 1 word/cycle with `note_valid` held high. A full page takes 32 cycles of WRITE.
- For the 32nd accept at edge K:
  - Cycle K+1 has `bram_we`=1 for word 31, `done`=1, `busy`=0, `note_ready`=0 and `count`=32.
  - Cycle K+2 is IDLE.
- `count` updates at the same edge as the accept. It holds after DONE or abort until the next `start`.
- The earliest next `start` is sampled in cycle K+2.

## Test plan
- Basic page:
  - Stimulus: `start_addr`=0x040, then 32 back-to-back words 0x1000..0x101F.
  - Required: writes at 0x040..0x05F with matching data, one per cycle, each 1 cycle after its accept.
  - Required: `done` is a single pulse coincident with the write of 0x101F, and `count`=32.
- Wrap:
  - Stimulus: `start_addr`=500, 32 words.
  - Required: addresses 500..511, then 0..19. No write lands outside this set.
- Backpressure gaps:
  - Stimulus: `note_valid` toggled in a random pattern.
  - Required: exactly 32 writes, in order, with no duplicates. `done` follows the 32nd accept by 1 cycle.
- Abort:
  - Stimulus: `abort` in the same cycle as `note_valid` after 10 accepts.
  - Required: `note_ready`=0 that cycle, so the 11th word is not written. `count`=10, no `done`, state IDLE.
- Reset and ignored start:
  - Stimulus 1: assert `reset_n`=0 asynchronously mid-page.
  - Required: all outputs go to 0 immediately.
  - Stimulus 2: after restart, pulse `start` with a new `start_addr` during WRITE.
  - Required: the pulse is ignored. The pointer continues from the original page.
